dtn_output_receive_buffer: RTL

- Sits directly downstream of one output port of the pipelined transport network.
- Absorbs nonblocking messages (valid/addr/data, no backpressure) into a circular FIFO.
- Re-presents them on a blocking valid/ready consumer interface for the processing element.
- Exports occupancy and an almost-full warning so the upstream static arbiter can throttle injection; a sticky overflow flag records lost messages.

---
 rtl/dtn_msg_pkg.sv | 18 +
 rtl/dtn_rx_fifo_mem.sv | 29 ++
 rtl/dtn_output_receive_buffer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/dtn_msg_pkg.sv
// Shared message definitions for the transport network receive path.
package dtn_msg_pkg;

  localparam int DTN_ADDR_WIDTH = 4;
  localparam int DTN_DATA_WIDTH = 64;

  // One network message as carried through the receive buffer.
  typedef struct packed {
    logic [DTN_ADDR_WIDTH-1:0] addr;
    logic [DTN_DATA_WIDTH-1:0] data;
  } dtn_msg_t;

  // Pointer width for a power-of-two circular buffer: index bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/dtn_rx_fifo_mem.sv
// Simple dual-port message storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module dtn_rx_fifo_mem
  import dtn_msg_pkg::*;
#(
  parameter int  DEPTH = 8,
  parameter int  AW    = $clog2(DEPTH),
  parameter type msg_t = dtn_msg_t
) (
  input  logic          clock,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  msg_t          wr_msg,
  input  logic [AW-1:0] rd_addr,
  output msg_t          rd_msg
);

  msg_t mem [DEPTH];

  // Write the incoming message into its slot.
  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_msg;
    end
  end

  assign rd_msg = mem[rd_addr];

endmodule

// File: rtl/dtn_output_receive_buffer.sv
// Receive buffer behind one transport network output port. Absorbs nonblocking
// messages into a circular FIFO and re-presents them on a valid/ready interface
// through a first-word fall-through output register. Occupancy, almost-full and a
// sticky overflow flag are exported for upstream throttling.
module dtn_output_receive_buffer
  import dtn_msg_pkg::*;
#(
  parameter int ADDR_WIDTH         = DTN_ADDR_WIDTH,
  parameter int DATA_WIDTH         = DTN_DATA_WIDTH,
  parameter int DEPTH              = 8,
  parameter int ALMOST_FULL_THRESH = 6
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [ADDR_WIDTH-1:0]    in_addr,
  input  logic [DATA_WIDTH-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ADDR_WIDTH-1:0]    out_addr,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     almost_full,
  output logic                     overflow,
  input  logic                     clear_overflow
);

  localparam int PW = ptr_width(DEPTH);
  localparam int IW = PW - 1;
  localparam logic [PW-1:0] PTR_ONE   = {{(PW-1){1'b0}}, 1'b1};
  localparam logic [PW-1:0] AF_THRESH = PW'(ALMOST_FULL_THRESH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } msg_t;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_next;
  logic [PW-1:0] rd_next;
  logic [PW-1:0] count_next;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          mem_wr_en;
  msg_t          in_msg;
  msg_t          rd_msg;
  msg_t          head_next;

  assign in_msg = '{addr: in_addr, data: in_data};

  dtn_rx_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (IW),
    .msg_t (msg_t)
  ) u_mem (
    .clock   (clock),
    .wr_en   (mem_wr_en),
    .wr_addr (wr_ptr[IW-1:0]),
    .wr_msg  (in_msg),
    .rd_addr (rd_next[IW-1:0]),
    .rd_msg  (rd_msg)
  );

  // Decide this cycle's push/pop/drop and the post-cycle pointers and head message.
  always_comb begin
    full       = (wr_ptr[IW] != rd_ptr[IW]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
    pop        = out_valid & out_ready;
    push       = in_valid & (~full | pop);
    drop       = in_valid & full & ~pop;
    mem_wr_en  = push & ~reset;
    wr_next    = wr_ptr;
    rd_next    = rd_ptr;
    head_next  = rd_msg;
    if (push) begin
      wr_next = wr_ptr + PTR_ONE;
    end else begin
      wr_next = wr_ptr;
    end
    if (pop) begin
      rd_next = rd_ptr + PTR_ONE;
    end else begin
      rd_next = rd_ptr;
    end
    count_next = wr_next - rd_next;
    // When the buffer is empty once the pop is applied, the new head is the message
    // being written this cycle; storage does not hold it yet, so take it from the input.
    if (push && (rd_next == wr_ptr)) begin
      head_next = in_msg;
    end else begin
      head_next = rd_msg;
    end
  end

  // Pointer, flag and output register update.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr      <= {PW{1'b0}};
      rd_ptr      <= {PW{1'b0}};
      out_valid   <= 1'b0;
      out_addr    <= {ADDR_WIDTH{1'b0}};
      out_data    <= {DATA_WIDTH{1'b0}};
      occupancy   <= {PW{1'b0}};
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      wr_ptr      <= wr_next;
      rd_ptr      <= rd_next;
      out_valid   <= (count_next != {PW{1'b0}});
      occupancy   <= count_next;
      almost_full <= (count_next >= AF_THRESH);
      if (count_next != {PW{1'b0}}) begin
        out_addr <= head_next.addr;
        out_data <= head_next.data;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop) begin
        overflow <= 1'b1;
      end else if (clear_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
